// File: rtl/brus16_fetch_pkg.sv
// Shared types and constants for the Brus16 instruction fetch unit.
package brus16_fetch_pkg;

  localparam int ROM_AW         = 13;
  localparam int WORD_W         = 16;
  localparam int ROM_RD_LATENCY = 1;

  typedef logic [ROM_AW-1:0] pc_t;
  typedef logic [WORD_W-1:0] word_t;

  // One buffered fetch result: the instruction word and the ROM address it came from.
  typedef struct packed {
    word_t instr;
    pc_t   pc;
  } fetch_entry_t;

endpackage

// File: rtl/brus16_fetch_if.sv
// Valid/ready instruction stream from the fetch unit to the decode stage.
interface brus16_fetch_if;
  import brus16_fetch_pkg::*;

  word_t instr;
  pc_t   instr_pc;
  logic  instr_valid;
  logic  instr_ready;

  modport master (output instr, output instr_pc, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_pc, input instr_valid, output instr_ready);
endinterface

// File: rtl/brus16_fetch_fifo.sv
// Small prefetch FIFO of fetch entries with synchronous flush.
// The head is read straight from the storage registers, so it only changes
// on a clock edge; an empty FIFO presents an all-zero head.
module brus16_fetch_fifo
  import brus16_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_pop  = pop && (r_count != '0) && !flush;
  assign w_do_push = push && !flush;
  assign head      = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;

  // Storage write; data registers need no reset because the count gates the head.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/brus16_fetch.sv
// Brus16 instruction fetch: drives the program ROM read port, absorbs its
// one-cycle read latency and hands PC-tagged words to decode over valid/ready.
module brus16_fetch
  import brus16_fetch_pkg::*;
#(
  parameter pc_t RESET_PC = 13'h0000,
  parameter int  DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  pc_t                   redirect_addr,
  brus16_fetch_if.master        dec,
  output pc_t                   rom_ad,
  output logic                  rom_ce,
  output logic                  rom_oce,
  output logic                  rom_reset,
  input  word_t                 rom_dout
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  pc_t              r_pc;
  logic             r_inflight;
  pc_t              r_inflight_pc;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  int               w_occ_next;

  // Issue decision. A redirect flushes the buffer and cancels the returning
  // read this cycle, so the projected occupancy is zero and the new target
  // is always issued when fetch is enabled.
  always_comb begin
    w_pop      = dec.instr_valid & dec.instr_ready;
    w_occ_next = 0;
    if (!redirect_valid) begin
      w_occ_next = int'(w_count) + int'(r_inflight) - int'(w_pop);
    end
    w_issue = reset_n & fetch_en & (w_occ_next < DEPTH);
    rom_ad  = redirect_valid ? redirect_addr : r_pc;
  end

  assign rom_ce      = w_issue;
  assign rom_oce     = w_issue;
  assign rom_reset   = ~reset_n;
  assign w_push      = r_inflight & ~redirect_valid;
  assign w_push_data = '{instr: rom_dout, pc: r_inflight_pc};

  assign dec.instr       = w_head.instr;
  assign dec.instr_pc    = w_head.pc;
  assign dec.instr_valid = (w_count != '0);

  brus16_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  // PC and in-flight tracking; a non-issuing redirect still retargets the PC.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= rom_ad + pc_t'(1);
        r_inflight_pc <= rom_ad;
      end else if (redirect_valid) begin
        r_pc <= redirect_addr;
      end
    end
  end

endmodule

// File: tb/tb_brus16_fetch.sv
// Directed bench for brus16_fetch with a behavioural ROM and an expected-PC scoreboard.
module tb_brus16_fetch;
  import brus16_fetch_pkg::*;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  fetch_en;
  logic  redirect_valid;
  pc_t   redirect_addr;
  pc_t   rom_ad;
  logic  rom_ce;
  logic  rom_oce;
  logic  rom_reset;
  word_t rom_dout = '0;

  int checks   = 0;
  int failures = 0;
  int consumed = 0;
  int n0;
  pc_t exp_q[$];

  logic  s_ce, s_oce, s_rst, s_valid;
  pc_t   s_ad, s_pc;
  word_t s_instr;
  word_t hold_instr;
  pc_t   hold_pc;

  brus16_fetch_if dec_if ();

  brus16_fetch #(
    .RESET_PC (13'h0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .dec            (dec_if),
    .rom_ad         (rom_ad),
    .rom_ce         (rom_ce),
    .rom_oce        (rom_oce),
    .rom_reset      (rom_reset),
    .rom_dout       (rom_dout)
  );

  always #5 clk = ~clk;

  function automatic word_t rom_word(input pc_t a);
    return 16'hA001 + {3'b000, a};
  endfunction

  // ROM model: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= rom_word(rom_ad);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_seq(input pc_t start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + pc_t'(i));
  endtask

  // One clock cycle: sample outputs mid-cycle, score any accepted word, then advance.
  task automatic step();
    pc_t e;
    @(negedge clk);
    s_ce    = rom_ce;
    s_oce   = rom_oce;
    s_rst   = rom_reset;
    s_ad    = rom_ad;
    s_valid = dec_if.instr_valid;
    s_instr = dec_if.instr;
    s_pc    = dec_if.instr_pc;
    if (s_valid && dec_if.instr_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", 32'(s_pc), 32'(e));
        chk("sb_instr", 32'(s_instr), 32'(rom_word(e)));
        consumed++;
        $display("pop pc=%04h instr=%04h", s_pc, s_instr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n             = 1'b0;
    fetch_en            = 1'b1;
    redirect_valid      = 1'b0;
    redirect_addr       = '0;
    dec_if.instr_ready  = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_ce", 32'(s_ce), 32'd0);
    chk("rst_oce", 32'(s_oce), 32'd0);
    chk("rst_rom_reset", 32'(s_rst), 32'd1);
    chk("rst_instr", 32'(s_instr), 32'd0);
    chk("rst_pc", 32'(s_pc), 32'd0);

    // Boot: first strobe right after release, first word two cycles later.
    load_seq(13'h0000, 64);
    reset_n = 1'b1;
    n0 = consumed;
    step();
    chk("boot_ce", 32'(s_ce), 32'd1);
    chk("boot_oce", 32'(s_oce), 32'd1);
    chk("boot_ad", 32'(s_ad), 32'd0);
    chk("boot_rom_reset", 32'(s_rst), 32'd0);
    step();
    chk("boot_gap_valid", 32'(s_valid), 32'd0);
    chk("boot_ad1", 32'(s_ad), 32'd1);
    step();
    chk("boot_first_valid", 32'(s_valid), 32'd1);
    chk("boot_first_instr", 32'(s_instr), 32'hA001);
    repeat (3) step();
    chk("boot_words", 32'(consumed - n0), 32'd4);

    // Backpressure: issue stops, head holds, nothing lost on release.
    dec_if.instr_ready = 1'b0;
    step();
    hold_instr = s_instr;
    hold_pc    = s_pc;
    chk("bp_ce_first", 32'(s_ce), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_ce", 32'(s_ce), 32'd0);
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_instr_hold", 32'(s_instr), 32'(hold_instr));
      chk("bp_pc_hold", 32'(s_pc), 32'(hold_pc));
    end
    dec_if.instr_ready = 1'b1;
    n0 = consumed;
    repeat (6) step();
    chk("bp_release_words", 32'(consumed - n0), 32'd6);

    // Fetch stall: in-flight read lands, buffer drains, then fetch resumes.
    fetch_en = 1'b0;
    step();
    chk("stall_ce", 32'(s_ce), 32'd0);
    step();
    step();
    chk("stall_drained", 32'(s_valid), 32'd0);
    fetch_en = 1'b1;
    n0 = consumed;
    repeat (5) step();
    chk("stall_resume_words", 32'(consumed - n0), 32'd3);

    // Redirect with a full buffer: stale words must never be delivered.
    dec_if.instr_ready = 1'b0;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 13'h0100;
    step();
    chk("rd_ce", 32'(s_ce), 32'd1);
    chk("rd_ad", 32'(s_ad), 32'h100);
    redirect_valid     = 1'b0;
    load_seq(13'h0100, 16);
    dec_if.instr_ready = 1'b1;
    step();
    chk("rd_gap_valid", 32'(s_valid), 32'd0);
    n0 = consumed;
    step();
    chk("rd_first_valid", 32'(s_valid), 32'd1);
    chk("rd_first_pc", 32'(s_pc), 32'h100);
    repeat (3) step();
    chk("rd_words", 32'(consumed - n0), 32'd4);

    // Back-to-back redirects: the second target wins.
    redirect_valid = 1'b1;
    redirect_addr  = 13'h0200;
    step();
    load_seq(13'h0300, 16);
    redirect_addr = 13'h0300;
    step();
    redirect_valid = 1'b0;
    step();
    chk("b2b_gap_valid", 32'(s_valid), 32'd0);
    step();
    chk("b2b_first_valid", 32'(s_valid), 32'd1);
    chk("b2b_first_pc", 32'(s_pc), 32'h300);
    repeat (2) step();

    // Redirect to the top address: PC wraps to zero.
    redirect_valid = 1'b1;
    redirect_addr  = 13'h1FFF;
    step();
    redirect_valid = 1'b0;
    load_seq(13'h1FFF, 16);
    step();
    n0 = consumed;
    repeat (3) step();
    chk("wrap_words", 32'(consumed - n0), 32'd3);
    chk("wrap_last_pc", 32'(s_pc), 32'h0001);

    // Reset mid-stream with a read in flight.
    dec_if.instr_ready = 1'b0;
    reset_n            = 1'b0;
    step();
    chk("mr_ce_during", 32'(s_ce), 32'd0);
    chk("mr_rom_reset_during", 32'(s_rst), 32'd1);
    step();
    chk("mr_valid", 32'(s_valid), 32'd0);
    chk("mr_instr", 32'(s_instr), 32'd0);
    chk("mr_pc", 32'(s_pc), 32'd0);
    chk("mr_ce", 32'(s_ce), 32'd0);
    chk("mr_rom_reset", 32'(s_rst), 32'd1);
    load_seq(13'h0000, 16);
    reset_n            = 1'b1;
    dec_if.instr_ready = 1'b1;
    step();
    chk("mr_restart_ce", 32'(s_ce), 32'd1);
    chk("mr_restart_ad", 32'(s_ad), 32'd0);
    step();
    step();
    chk("mr_restart_valid", 32'(s_valid), 32'd1);
    chk("mr_restart_pc", 32'(s_pc), 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
